// File: rtl/aesl_deadlock_persist_monitor_if.sv
// Bundle of block/idle flags, clear and report outputs of the persistent
// deadlock monitor.
//   master : drives the flags and clear, observes the report (bench / upstream)
//   slave  : the monitor itself
// Ports: none (pure signal bundle); clock and reset stay on the module.
interface aesl_deadlock_persist_monitor_if #(
  parameter int N_AXIS = 5,
  parameter int N_SUB  = 5,
  parameter int N_IDLE = 14,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = $clog2(N_AXIS + N_SUB)
);
  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_IDLE-1:0] inst_idle_sigs;
  logic [N_SUB-1:0]  inst_block_sigs;
  logic              clear;
  logic              block;
  logic [IDX_W-1:0]  block_idx;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  block, block_idx, stall_cycles
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output block, block_idx, stall_cycles
  );
endinterface

// File: rtl/aesl_deadlock_persist_monitor.sv
// Persistent deadlock monitor.
// Watches masked AXI-stream block flags and sub-instance block flags, and
// reports a deadlock only once the block condition has persisted THRESHOLD
// consecutive cycles. Reports the first offending channel and how long the
// stall has lasted; optional sticky mode holds the report until clear.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave modport carrying axis_block_sigs, inst_idle_sigs,
//           inst_block_sigs, clear (in) and block, block_idx,
//           stall_cycles (out, all registered)
module aesl_deadlock_persist_monitor #(
  parameter int                N_AXIS    = 5,
  parameter int                N_SUB     = 5,
  parameter int                N_IDLE    = 14,
  parameter logic [N_AXIS-1:0] AXIS_MASK = '1,
  parameter int                THRESHOLD = 1,
  parameter int                STICKY    = 0,
  parameter int                CNT_W     = 16,
  parameter int                IDX_W     = $clog2(N_AXIS + N_SUB)
) (
  input logic                            clock,
  input logic                            reset,
  aesl_deadlock_persist_monitor_if.slave bus
);

  localparam int THR_W = $clog2(THRESHOLD + 1);
  localparam logic [THR_W-1:0] CNT_LAST = THR_W'(THRESHOLD - 1);

  typedef enum logic [1:0] {IDLE, SUSPECT, BLOCKED} state_t;

  state_t            state_q, state_d;
  logic [THR_W-1:0]  cnt_q, cnt_d;
  logic              block_q, block_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic [N_AXIS-1:0] axis_masked;
  logic              cond;
  logic [IDX_W-1:0]  first_idx;

  assign axis_masked = bus.axis_block_sigs & AXIS_MASK;
  // All instances idle means the design has simply finished: no deadlock.
  assign cond = (|axis_masked | |bus.inst_block_sigs) & ~(&bus.inst_idle_sigs);

  // Lowest masked AXIS bit wins; sub-instance flags are only consulted when
  // no AXIS channel is blocked. Scanning downward leaves the lowest index.
  always_comb begin
    first_idx = '0;
    for (int i = N_SUB - 1; i >= 0; i--) begin
      if (bus.inst_block_sigs[i]) first_idx = IDX_W'(N_AXIS + i);
    end
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (axis_masked[i]) first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      block_q <= 1'b0;
      idx_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      idx_q   <= idx_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    idx_d   = idx_q;
    stall_d = stall_q;
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      block_d = 1'b0;
      idx_d   = '0;
      stall_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cond) begin
            // Offending channel is latched only here, on leaving IDLE.
            idx_d = first_idx;
            if (THRESHOLD == 1) begin
              state_d = BLOCKED;
              block_d = 1'b1;
              stall_d = CNT_W'(1);
            end else begin
              state_d = SUSPECT;
              cnt_d   = THR_W'(1);
            end
          end
        end
        SUSPECT: begin
          if (!cond) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = BLOCKED;
            cnt_d   = '0;
            block_d = 1'b1;
            stall_d = CNT_W'(1);
          end else begin
            cnt_d = cnt_q + THR_W'(1);
          end
        end
        BLOCKED: begin
          if (STICKY == 0 && !cond) begin
            state_d = IDLE;
            block_d = 1'b0;
            stall_d = '0;
          end else if (stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          block_d = 1'b0;
          stall_d = '0;
        end
      endcase
    end
  end

  assign bus.block        = block_q;
  assign bus.block_idx    = idx_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_aesl_deadlock_persist_monitor.sv
module tb_aesl_deadlock_persist_monitor;

  logic clock;
  logic reset;
  int   passed;
  int   total;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  aesl_deadlock_persist_monitor_if #(.N_AXIS(5), .N_SUB(5), .N_IDLE(14), .CNT_W(16)) i1 ();
  aesl_deadlock_persist_monitor_if #(.N_AXIS(5), .N_SUB(5), .N_IDLE(14), .CNT_W(16)) i2 ();
  aesl_deadlock_persist_monitor_if #(.N_AXIS(5), .N_SUB(5), .N_IDLE(14), .CNT_W(16)) i3 ();
  aesl_deadlock_persist_monitor_if #(.N_AXIS(5), .N_SUB(5), .N_IDLE(14), .CNT_W(16)) i4 ();
  aesl_deadlock_persist_monitor_if #(.N_AXIS(5), .N_SUB(5), .N_IDLE(14), .CNT_W(3))  i6 ();

  // Default configuration: THRESHOLD=1, STICKY=0
  aesl_deadlock_persist_monitor #(.THRESHOLD(1)) d1 (.clock(clock), .reset(reset), .bus(i1));
  aesl_deadlock_persist_monitor #(.THRESHOLD(4)) d2 (.clock(clock), .reset(reset), .bus(i2));
  aesl_deadlock_persist_monitor #(.AXIS_MASK(5'b11110)) d3 (.clock(clock), .reset(reset), .bus(i3));
  aesl_deadlock_persist_monitor #(.THRESHOLD(2), .STICKY(1)) d4 (.clock(clock), .reset(reset), .bus(i4));
  aesl_deadlock_persist_monitor #(.CNT_W(3)) d6 (.clock(clock), .reset(reset), .bus(i6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    i1.axis_block_sigs = '0; i1.inst_idle_sigs = '0; i1.inst_block_sigs = '0; i1.clear = 1'b0;
    i2.axis_block_sigs = '0; i2.inst_idle_sigs = '0; i2.inst_block_sigs = '0; i2.clear = 1'b0;
    i3.axis_block_sigs = '0; i3.inst_idle_sigs = '0; i3.inst_block_sigs = '0; i3.clear = 1'b0;
    i4.axis_block_sigs = '0; i4.inst_idle_sigs = '0; i4.inst_block_sigs = '0; i4.clear = 1'b0;
    i6.axis_block_sigs = '0; i6.inst_idle_sigs = '0; i6.inst_block_sigs = '0; i6.clear = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_block", {31'd0, i1.block}, 32'd0);
    chk("rst_idx", {28'd0, i1.block_idx}, 32'd0);
    chk("rst_stall", {16'd0, i1.stall_cycles}, 32'd0);
    reset = 1'b1;
    step();
    chk("idle_block", {31'd0, i1.block}, 32'd0);

    // Test 1: THRESHOLD=1 follows the condition one cycle later
    i1.axis_block_sigs = 5'b00100;
    step();
    chk("t1_block_c1", {31'd0, i1.block}, 32'd1);
    chk("t1_idx", {28'd0, i1.block_idx}, 32'd2);
    chk("t1_stall_c1", {16'd0, i1.stall_cycles}, 32'd1);
    step();
    chk("t1_stall_c2", {16'd0, i1.stall_cycles}, 32'd2);
    step();
    chk("t1_block_c3", {31'd0, i1.block}, 32'd1);
    chk("t1_stall_c3", {16'd0, i1.stall_cycles}, 32'd3);
    i1.axis_block_sigs = 5'b00000;
    step();
    chk("t1_block_drop", {31'd0, i1.block}, 32'd0);
    chk("t1_stall_drop", {16'd0, i1.stall_cycles}, 32'd0);
    chk("t1_idx_kept", {28'd0, i1.block_idx}, 32'd2);

    // Test 5: all idle masks every block flag
    i1.inst_idle_sigs  = '1;
    i1.axis_block_sigs = 5'b11111;
    i1.inst_block_sigs = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_allidle", {31'd0, i1.block}, 32'd0);
    end
    i1.inst_idle_sigs  = '0;
    i1.axis_block_sigs = '0;
    i1.inst_block_sigs = '0;

    // Test 2: THRESHOLD=4, short pulse must be filtered
    i2.inst_block_sigs = 5'b01000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_pulse", {31'd0, i2.block}, 32'd0);
    end
    i2.inst_block_sigs = 5'b00000;
    step();
    step();
    chk("t2_gap", {31'd0, i2.block}, 32'd0);
    i2.inst_block_sigs = 5'b01000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_hold_pre", {31'd0, i2.block}, 32'd0);
    end
    step();
    chk("t2_block_4th", {31'd0, i2.block}, 32'd1);
    chk("t2_idx", {28'd0, i2.block_idx}, 32'd8);
    chk("t2_stall", {16'd0, i2.stall_cycles}, 32'd1);
    step();
    step();
    chk("t2_stall_3", {16'd0, i2.stall_cycles}, 32'd3);
    i2.inst_block_sigs = 5'b00000;
    step();
    chk("t2_release", {31'd0, i2.block}, 32'd0);

    // Test 3: masked channel ignored, unmasked one reported
    i3.axis_block_sigs = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_masked", {31'd0, i3.block}, 32'd0);
    end
    i3.axis_block_sigs = 5'b00011;
    step();
    chk("t3_block", {31'd0, i3.block}, 32'd1);
    chk("t3_idx", {28'd0, i3.block_idx}, 32'd1);
    i3.axis_block_sigs = 5'b00000;

    // Test 4: STICKY=1, THRESHOLD=2
    i4.axis_block_sigs = 5'b00001;
    step();
    chk("t4_suspect", {31'd0, i4.block}, 32'd0);
    step();
    chk("t4_block", {31'd0, i4.block}, 32'd1);
    chk("t4_stall1", {16'd0, i4.stall_cycles}, 32'd1);
    i4.axis_block_sigs = 5'b00000;
    step();
    chk("t4_sticky", {31'd0, i4.block}, 32'd1);
    chk("t4_stall2", {16'd0, i4.stall_cycles}, 32'd2);
    step();
    chk("t4_stall3", {16'd0, i4.stall_cycles}, 32'd3);
    i4.clear = 1'b1;
    step();
    chk("t4_clr_block", {31'd0, i4.block}, 32'd0);
    chk("t4_clr_stall", {16'd0, i4.stall_cycles}, 32'd0);
    i4.clear = 1'b0;
    step();
    chk("t4_after_clr", {31'd0, i4.block}, 32'd0);

    // Test 6: CNT_W=3 saturation, then asynchronous reset mid-stall
    i6.axis_block_sigs = 5'b00100;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t6_stall", {29'd0, i6.stall_cycles}, (k < 7) ? k : 7);
    end
    chk("t6_block", {31'd0, i6.block}, 32'd1);
    chk("t6_idx", {28'd0, i6.block_idx}, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_block", {31'd0, i6.block}, 32'd0);
    chk("t6_async_stall", {29'd0, i6.stall_cycles}, 32'd0);
    chk("t6_async_idx", {28'd0, i6.block_idx}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
